// File: rtl/ram_ctrl.sv
// Host-side sequencer for the banked 8-bit RAM: accepts one load/store at a time,
// inserts a bank select only on a bank change, then issues a single RAM command.
module ram_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [1:0] req_bank,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       ram_re,
  output logic       ram_sb,
  input  logic [7:0] ram_datao
);

  // state   | meaning
  // GUARD   | post-reset wait so an interrupted RAM command can finish
  // IDLE    | ready for a host request
  // SETBANK | bank-select strobe to the RAM
  // SBWAIT  | RAM executing the bank select
  // ISSUE   | write or read strobe to the RAM
  // WAIT    | RAM executing the access
  // CAPTURE | read data valid on ram_datao, register it
  // DONE    | response pulse to the host
  localparam logic [2:0] GUARD   = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] SETBANK = 3'd2;
  localparam logic [2:0] SBWAIT  = 3'd3;
  localparam logic [2:0] ISSUE   = 3'd4;
  localparam logic [2:0] WAIT    = 3'd5;
  localparam logic [2:0] CAPTURE = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0] state, state_nx;
  logic [1:0] guard_cnt;
  logic       we_q;
  logic [1:0] bank_q;
  logic [7:0] addr_q, wdata_q;
  logic [1:0] cur_bank;
  logic       bank_valid;
  logic       accept;
  logic       tx_we;
  logic [1:0] tx_bank;
  logic [7:0] tx_addr, tx_wdata;

  assign accept = (state == IDLE) && req_valid;

  // Outputs are registered from the next state, so the request fields must be
  // taken straight from the port on the accept cycle.
  assign tx_we    = accept ? req_we    : we_q;
  assign tx_bank  = accept ? req_bank  : bank_q;
  assign tx_addr  = accept ? req_addr  : addr_q;
  assign tx_wdata = accept ? req_wdata : wdata_q;

  always_comb begin
    state_nx = state;
    case (state)
      GUARD:   if (guard_cnt == 2'd0) state_nx = IDLE;
      IDLE:    if (req_valid)
                 state_nx = (bank_valid && (req_bank == cur_bank)) ? ISSUE : SETBANK;
      SETBANK: state_nx = SBWAIT;
      SBWAIT:  state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = we_q ? DONE : CAPTURE;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = GUARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= GUARD;
      guard_cnt  <= 2'd2;
      we_q       <= 1'b0;
      bank_q     <= 2'd0;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      cur_bank   <= 2'd0;
      bank_valid <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 8'd0;
      ram_addr   <= 8'd0;
      ram_data   <= 8'd0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_sb     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == GUARD && guard_cnt != 2'd0) guard_cnt <= guard_cnt - 2'd1;
      if (accept) begin
        we_q    <= req_we;
        bank_q  <= req_bank;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      req_ready  <= (state_nx == IDLE);
      resp_valid <= (state_nx == DONE);
      ram_sb     <= (state_nx == SETBANK);
      ram_we     <= (state_nx == ISSUE) && tx_we;
      ram_re     <= (state_nx == ISSUE) && !tx_we;
      if (state_nx == SETBANK) begin
        ram_data   <= {6'b0, tx_bank};
        cur_bank   <= tx_bank;
        bank_valid <= 1'b1;
      end
      if (state_nx == ISSUE) begin
        ram_addr <= tx_addr;
        if (tx_we) ram_data <= tx_wdata;
      end
      if (state == CAPTURE) resp_rdata <= ram_datao;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed request table against a banked RAM
// model, plus back-to-back, reset-abort and post-reset guard sequences.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_bank;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       ram_re;
  logic       ram_sb;
  logic [7:0] ram_datao = 8'h00;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .ram_re(ram_re), .ram_sb(ram_sb),
    .ram_datao(ram_datao)
  );

  // Banked RAM: samples only when idle, one execute cycle per command,
  // read data lands on the edge that ends the execute cycle.
  logic [7:0] mem [4][256];
  logic [1:0] rbank = 2'd0;
  logic       busy = 1'b0;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  int         proto_err = 0;

  always @(posedge clk) begin
    if (!busy) begin
      if (ram_we) begin
        mem[rbank][ram_addr] <= ram_data;
        busy <= 1'b1; rd_pend <= 1'b0;
      end else if (ram_re) begin
        rd_addr <= ram_addr;
        busy <= 1'b1; rd_pend <= 1'b1;
      end else if (ram_sb) begin
        rbank <= ram_data[1:0];
        busy <= 1'b1; rd_pend <= 1'b0;
      end
    end else begin
      if (ram_we || ram_re || ram_sb) proto_err = proto_err + 1;
      busy <= 1'b0;
      if (rd_pend) ram_datao <= mem[rbank][rd_addr];
    end
  end

  int   overlap_err = 0, ready_err = 0, repeat_err = 0, we_total = 0;
  logic prev_we = 1'b0, prev_re = 1'b0, prev_sb = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!$onehot0({ram_we, ram_re, ram_sb})) overlap_err = overlap_err + 1;
      if (req_ready && (ram_we || ram_re || ram_sb || resp_valid)) ready_err = ready_err + 1;
      if ((ram_we && prev_we) || (ram_re && prev_re) || (ram_sb && prev_sb)) repeat_err = repeat_err + 1;
      if (ram_we) we_total = we_total + 1;
    end
    prev_we = ram_we; prev_re = ram_re; prev_sb = ram_sb;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] bank, input logic [7:0] addr,
                        input logic [7:0] wdata, output int lat, output int sb_cnt,
                        output logic [7:0] sb_data, output int strobe_cyc,
                        output int we_cnt, output int re_cnt, output logic [7:0] w_addr,
                        output logic [7:0] w_data, output logic [7:0] rdata);
    int t = 0;
    lat = -1; sb_cnt = 0; sb_data = 8'h00; strobe_cyc = -1;
    we_cnt = 0; re_cnt = 0; w_addr = 8'h00; w_data = 8'h00; rdata = 8'h00;
    @(negedge clk);
    while (!req_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1; req_we = we; req_bank = bank; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ram_sb) begin sb_cnt++; sb_data = ram_data; end
      if (ram_we) begin we_cnt++; strobe_cyc = n; w_addr = ram_addr; w_data = ram_data; end
      if (ram_re) begin re_cnt++; strobe_cyc = n; end
      if (resp_valid) begin lat = n; rdata = resp_rdata; break; end
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] bank;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_sb;
    int         exp_lat;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, sb_cnt, strobe_cyc, we_cnt, re_cnt;
    logic [7:0] sb_data, w_addr, w_data, rdata;
    int acc_cyc[$];
    int cyc, idx, drain, we_before, resp_seen;
    logic pend;

    vecs[0]  = '{1'b1, 2'd1, 8'h10, 8'hA5, 1'b1, 5, 8'h00};
    vecs[1]  = '{1'b0, 2'd1, 8'h10, 8'h00, 1'b0, 4, 8'hA5};
    vecs[2]  = '{1'b1, 2'd1, 8'h20, 8'h3C, 1'b0, 3, 8'h00};
    vecs[3]  = '{1'b1, 2'd0, 8'h10, 8'h5A, 1'b1, 5, 8'h00};
    vecs[4]  = '{1'b0, 2'd0, 8'h10, 8'h00, 1'b0, 4, 8'h5A};
    vecs[5]  = '{1'b0, 2'd1, 8'h20, 8'h00, 1'b1, 6, 8'h3C};
    vecs[6]  = '{1'b0, 2'd0, 8'h10, 8'h00, 1'b1, 6, 8'h5A};
    vecs[7]  = '{1'b0, 2'd1, 8'h10, 8'h00, 1'b1, 6, 8'hA5};
    vecs[8]  = '{1'b1, 2'd3, 8'hFF, 8'h81, 1'b1, 5, 8'h00};
    vecs[9]  = '{1'b0, 2'd3, 8'hFF, 8'h00, 1'b0, 4, 8'h81};
    vecs[10] = '{1'b0, 2'd0, 8'h10, 8'h00, 1'b1, 6, 8'h5A};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_bank = 2'd0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_rdata", int'(resp_rdata), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_data", int'(ram_data), 0);
    check("rst_strobes", int'({ram_we, ram_re, ram_sb}), 0);

    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk); check("guard_c1_ready", int'(req_ready), 0);
    @(negedge clk); check("guard_c2_ready", int'(req_ready), 0);
    @(negedge clk); check("guard_c3_ready", int'(req_ready), 1);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].we, vecs[i].bank, vecs[i].addr, vecs[i].wdata,
             lat, sb_cnt, sb_data, strobe_cyc, we_cnt, re_cnt, w_addr, w_data, rdata);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_sb_count", i), sb_cnt, int'(vecs[i].exp_sb));
      if (vecs[i].exp_sb) check($sformatf("v%0d_sb_data", i), int'(sb_data), int'({6'b0, vecs[i].bank}));
      check($sformatf("v%0d_strobe_cycle", i), strobe_cyc, vecs[i].exp_sb ? 3 : 1);
      if (vecs[i].we) begin
        check($sformatf("v%0d_we_count", i), we_cnt, 1);
        check($sformatf("v%0d_re_count", i), re_cnt, 0);
        check($sformatf("v%0d_we_addr", i), int'(w_addr), int'(vecs[i].addr));
        check($sformatf("v%0d_we_data", i), int'(w_data), int'(vecs[i].wdata));
      end else begin
        check($sformatf("v%0d_re_count", i), re_cnt, 1);
        check($sformatf("v%0d_we_count", i), we_cnt, 0);
        check($sformatf("v%0d_rdata", i), int'(rdata), int'(vecs[i].exp_rdata));
      end
    end

    // Four stores to bank 2 with req_valid held high throughout.
    cyc = 0; idx = 0; drain = 0; we_before = we_total;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (idx < 4) begin
        req_valid = 1'b1; req_we = 1'b1; req_bank = 2'd2;
        req_addr = 8'(8'h30 + idx); req_wdata = 8'(8'hC0 + idx);
      end else begin
        req_valid = 1'b0;
      end
      pend = req_valid && req_ready;
      @(posedge clk);
      cyc++;
      if (pend) begin acc_cyc.push_back(cyc); idx++; end
      if (idx == 4) begin
        drain++;
        if (drain > 8) break;
      end
    end
    check("b2b_accepts", idx, 4);
    if (idx == 4) begin
      check("b2b_gap0", acc_cyc[1] - acc_cyc[0], 6);
      check("b2b_gap1", acc_cyc[2] - acc_cyc[1], 4);
      check("b2b_gap2", acc_cyc[3] - acc_cyc[2], 4);
    end
    check("b2b_we_pulses", we_total - we_before, 4);

    do_req(1'b0, 2'd2, 8'h33, 8'h00, lat, sb_cnt, sb_data, strobe_cyc, we_cnt, re_cnt, w_addr, w_data, rdata);
    check("b2b_readback_latency", lat, 4);
    check("b2b_readback_rdata", int'(rdata), 8'hC3);

    // Reset asserted while a bank-hit load sits in WAIT.
    @(negedge clk);
    for (int t = 0; t < 40 && !req_ready; t++) @(negedge clk);
    check("abort_ready", int'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b0; req_bank = 2'd2; req_addr = 8'h30;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_re_cycle1", int'(ram_re), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_strobes", int'({ram_we, ram_re, ram_sb}), 0);
    check("abort_resp_valid", int'(resp_valid), 0);
    check("abort_ready_low", int'(req_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    resp_seen = 0;
    @(negedge clk); check("abort_guard_c1", int'(req_ready), 0); resp_seen += int'(resp_valid);
    @(negedge clk); check("abort_guard_c2", int'(req_ready), 0); resp_seen += int'(resp_valid);
    @(negedge clk); check("abort_guard_c3", int'(req_ready), 1); resp_seen += int'(resp_valid);
    check("abort_no_resp", resp_seen, 0);

    do_req(1'b1, 2'd2, 8'h44, 8'h77, lat, sb_cnt, sb_data, strobe_cyc, we_cnt, re_cnt, w_addr, w_data, rdata);
    check("post_abort_sb", sb_cnt, 1);
    check("post_abort_sb_data", int'(sb_data), 2);
    check("post_abort_latency", lat, 5);
    do_req(1'b0, 2'd2, 8'h44, 8'h00, lat, sb_cnt, sb_data, strobe_cyc, we_cnt, re_cnt, w_addr, w_data, rdata);
    check("post_abort_rdata", int'(rdata), 8'h77);

    check("strobe_overlap", overlap_err, 0);
    check("ready_outside_idle", ready_err, 0);
    check("strobe_repeat", repeat_err, 0);
    check("ram_busy_strobe", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Host-side sequencer for the banked 8-bit RAM. It accepts single load/store requests from the core over a valid/ready handshake, tracks which bank is currently selected in the RAM, and inserts a bank-select command only when the target bank changes. It then issues exactly one one-cycle write or read command and returns an acknowledge, plus read data for reads. It sits directly upstream of the RAM, drives all of its command inputs and consumes its data output.

## Interface
- No parameters. Widths are fixed: 8-bit address, 8-bit data, 2-bit bank.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  host request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_bank  in  2  target bank
- req_addr  in  8  word address within bank
- req_wdata  in  8  store data
- resp_valid  out  1  one-cycle pulse: request completed
- resp_rdata  out  8  load data, valid when resp_valid and request was a load
- ram_addr  out  8  to RAM Address
- ram_data  out  8  to RAM Data (store data, or bank number during bank select)
- ram_we  out  1  to RAM WE
- ram_re  out  1  to RAM RE
- ram_sb  out  1  to RAM SB
- ram_datao  in  8  from RAM read data output

## Operation
- RAM protocol:
  - The RAM samples Address, Data and its command strobes only in its idle state.
  - It spends exactly one cycle executing each command.
  - Read data appears on ram_datao at the edge that ends the execute cycle.
  - Only one strobe is ever high at a time, and each strobe is high for exactly one cycle.
- State machine states: GUARD, IDLE, SETBANK, SBWAIT, ISSUE, WAIT, CAPTURE, DONE.
- GUARD:
  - Entered on reset. Stays for 2 cycles, counted by a 2-bit counter, so that a RAM interrupted mid-command can return to idle.
  - req_ready=0. Then goes to IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/bank/addr/wdata.
  - If bank_valid and req_bank==cur_bank, go to ISSUE. Otherwise go to SETBANK.
- SETBANK:
  - ram_sb=1, ram_data={6'b0,bank}.
  - Set cur_bank=bank and bank_valid=1. Go to SBWAIT.
- SBWAIT: all strobes 0. Go to ISSUE.
- ISSUE:
  - ram_addr=addr.
  - Store: ram_data=wdata and ram_we=1. Load: ram_re=1.
  - Go to WAIT.
- WAIT: strobes 0. Store goes to DONE; load goes to CAPTURE.
- CAPTURE: resp_rdata <= ram_datao. Go to DONE.
- DONE: resp_valid=1. Go to IDLE.
- ram_addr and ram_data hold their last driven value when not in ISSUE or SETBANK.
- resp_rdata holds its value until the next load completes.
- bank_valid is cleared by reset, so the first access after reset always issues a bank select.
- req_ready is low in every state except IDLE. No request is queued. Requests presented while busy are held by the host.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0.
  - ram_addr=0, ram_data=0, ram_we=0, ram_re=0, ram_sb=0.
  - State=GUARD, cur_bank=0, bank_valid=0.
- First accept is possible in cycle 3 after the cycle in which rst_n is sampled high.
- Latency, counting from the accept edge (cycle 0) to resp_valid:
  - Bank hit: store at cycle 3, load at cycle 4.
  - Bank miss: adds 2 cycles, so store at cycle 5, load at cycle 6.
- Back-to-back: req_ready rises in the cycle after resp_valid. Minimum spacing between accepts is 4 cycles for a store hit and 5 cycles for a load hit.
- Reset mid-transaction:
  - Abort immediately. All strobes drop in the next cycle and no resp_valid is issued.
  - Enter GUARD and invalidate the bank.
- Bank register width is 2 bits. Bank select always drives bits [7:2] of ram_data to 0.

## Test plan
- Reset, then store bank 1, addr 0x10, data 0xA5 -> ram_sb pulse with ram_data=0x01, ram_we pulse with addr 0x10 / data 0xA5 two cycles later, resp_valid at cycle 5.
- Load bank 1, addr 0x10 right after the previous store -> no ram_sb, ram_re pulse at cycle 1, resp_valid at cycle 4 with resp_rdata=0xA5.
- Alternate banks 0/1/0 on loads -> ram_sb issued on every request, each with the correct ram_data bank value; resp_valid at cycle 6 each time.
- Hold req_valid high continuously with 4 queued stores to bank 2 -> exactly one ram_we per accept, no strobe overlap, req_ready=0 except in IDLE.
- Assert rst_n=0 during WAIT of a load -> no resp_valid, strobes 0, req_ready low for 2 cycles after release, next access issues ram_sb.
- After reset, check every output equals its reset value and that req_ready stays 0 for exactly 2 cycles.
